// File: rtl/melody_seq.sv
// Score-RAM driven melody sequencer: plays {len, div} entries as a square wave
// on beep, with fixed beat length, inter-note gap, loop and stop control.
module melody_seq #(
  parameter int unsigned DIV_W    = 32,
  parameter int unsigned LEN_W    = 4,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned BEAT_CYC = 12_500_000,
  parameter int unsigned GAP_CYC  = 500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DIV_W-1:0]  wr_div,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic              beep,
  output logic              busy,
  output logic [ADDR_W-1:0] note_idx,
  output logic [DIV_W-1:0]  cur_div,
  output logic              done
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned BC_W  = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;
  localparam int unsigned GC_W  = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(BEAT_CYC - 1);
  localparam logic [GC_W-1:0]   GC_LAST  = GC_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [DIV_W-1:0]  cur_div_q, cur_div_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic [GC_W-1:0]   gap_q, gap_d;
  logic [DIV_W-1:0]  tone_q, tone_d;
  logic              beep_q, beep_d;
  logic              done_q, done_d;
  logic              adv, eos;

  logic [DIV_W-1:0]  div_mem [DEPTH];
  logic [LEN_W-1:0]  len_mem [DEPTH];
  logic [DIV_W-1:0]  ent_div;
  logic [LEN_W-1:0]  ent_len;

  // Score storage is deliberately outside the reset domain.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      div_mem[wr_addr] <= wr_div;
      len_mem[wr_addr] <= wr_len;
    end
  end

  assign ent_div = div_mem[ptr_q];
  assign ent_len = len_mem[ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cur_div_q <= '0;
      len_q     <= '0;
      bc_q      <= '0;
      beat_q    <= '0;
      gap_q     <= '0;
      tone_q    <= '0;
      beep_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cur_div_q <= cur_div_d;
      len_q     <= len_d;
      bc_q      <= bc_d;
      beat_q    <= beat_d;
      gap_q     <= gap_d;
      tone_q    <= tone_d;
      beep_q    <= beep_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cur_div_d = cur_div_q;
    len_d     = len_q;
    bc_d      = bc_q;
    beat_d    = beat_q;
    gap_d     = gap_q;
    tone_d    = tone_q;
    beep_d    = beep_q;
    done_d    = 1'b0;
    adv       = 1'b0;
    eos       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        beep_d    = 1'b0;
        cur_div_d = '0;
        if (start && !stop) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      S_LOAD: begin
        cur_div_d = ent_div;
        len_d     = ent_len;
        if (ent_len != '0) begin
          state_d = S_PLAY;
          bc_d    = '0;
          beat_d  = '0;
          tone_d  = '0;
          beep_d  = 1'b0;
        end else begin
          eos = 1'b1;
        end
      end
      S_PLAY: begin
        if (cur_div_q == '0) begin
          beep_d = 1'b0;
          tone_d = '0;
        end else if (tone_q == cur_div_q - DIV_W'(1)) begin
          beep_d = ~beep_q;
          tone_d = '0;
        end else begin
          tone_d = tone_q + DIV_W'(1);
        end
        if (bc_q == BC_LAST) begin
          bc_d = '0;
          if (beat_q == len_q - LEN_W'(1)) begin
            beep_d = 1'b0;
            tone_d = '0;
            if (GAP_CYC != 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end else begin
              adv = 1'b1;
            end
          end else begin
            beat_d = beat_q + LEN_W'(1);
          end
        end else begin
          bc_d = bc_q + BC_W'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GC_LAST) begin
          adv = 1'b1;
        end else begin
          gap_d = gap_q + GC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (adv) begin
      if (ptr_q == PTR_LAST) begin
        eos = 1'b1;
      end else begin
        ptr_d   = ptr_q + ADDR_W'(1);
        state_d = S_LOAD;
      end
    end

    if (eos) begin
      if (loop_en) begin
        ptr_d   = '0;
        state_d = S_LOAD;
      end else begin
        state_d   = S_IDLE;
        cur_div_d = '0;
        done_d    = 1'b1;
      end
    end

    // Abort overrides every transition above, including a completing one.
    if (stop && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      cur_div_d = '0;
      beep_d    = 1'b0;
      done_d    = 1'b0;
      tone_d    = '0;
      bc_d      = '0;
      beat_d    = '0;
      gap_d     = '0;
    end
  end

  assign beep     = beep_q;
  assign busy     = (state_q != S_IDLE);
  assign note_idx = ptr_q;
  assign cur_div  = cur_div_q;
  assign done     = done_q;

endmodule

// File: tb/tb_melody_seq.sv
// Self-checking bench for melody_seq: timeline-based reference model compared
// every cycle, plus hand-computed latency literals for the directed scenarios.
module tb_melody_seq;

  localparam int B     = 8;
  localparam int G     = 2;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_div = '0;
  logic [3:0]  wr_len = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        loop_en = 1'b0;
  logic        beep, busy, done;
  logic [2:0]  note_idx;
  logic [31:0] cur_div;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  melody_seq #(
    .DIV_W(32), .LEN_W(4), .ADDR_W(3), .BEAT_CYC(B), .GAP_CYC(G)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_div(wr_div),
    .wr_len(wr_len), .start(start), .stop(stop), .loop_en(loop_en),
    .beep(beep), .busy(busy), .note_idx(note_idx), .cur_div(cur_div), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a note is a timeline of k = cycles since its first
  // tone cycle; tone for k < len*B, silence until len*B+G, then next fetch.
  int          m_len_mem [DEPTH];
  int          m_div_mem [DEPTH];
  bit          m_busy = 0, m_loading = 0, m_done = 0;
  int          m_ptr = 0, m_k = 0, m_len = 0, m_div = 0;

  function automatic void m_end_of_score();
    if (loop_en) begin
      m_ptr     = 0;
      m_loading = 1;
    end else begin
      m_busy = 0;
      m_done = 1;
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 0; m_loading = 0; m_done = 0; m_ptr = 0; m_k = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (start && !stop) begin
          m_busy = 1; m_loading = 1; m_ptr = 0;
        end
      end else if (stop) begin
        m_busy = 0;
      end else if (m_loading) begin
        if (m_len_mem[m_ptr] != 0) begin
          m_loading = 0;
          m_len     = m_len_mem[m_ptr];
          m_div     = m_div_mem[m_ptr];
          m_k       = 0;
        end else begin
          m_end_of_score();
        end
      end else begin
        m_k++;
        if (m_k == m_len * B + G) begin
          if (m_ptr == DEPTH - 1) m_end_of_score();
          else begin
            m_ptr++;
            m_loading = 1;
          end
        end
      end
      if (wr_en) begin
        m_len_mem[wr_addr] = int'(wr_len);
        m_div_mem[wr_addr] = int'(wr_div);
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      logic exp_beep;
      exp_beep = 1'b0;
      if (m_busy && !m_loading && m_k < m_len * B && m_div != 0)
        exp_beep = ((m_k / m_div) % 2) == 1;
      check("busy", busy, m_busy);
      check("done", done, m_done);
      check("beep", beep, exp_beep);
      if (m_busy) check("note_idx", note_idx, m_ptr);
      if (!m_busy) check("cur_div_idle", cur_div, 0);
      else if (!m_loading) check("cur_div", cur_div, m_div);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_entry(input int a, input int l, input int d);
    wr_en = 1'b1; wr_addr = 3'(a); wr_len = 4'(l); wr_div = 32'(d);
    step();
    wr_en = 1'b0;
  endtask

  // Latencies are counted from the edge that samples start.
  task automatic play_until_done(input string name, input int budget,
                                 input int exp_lat, input int exp_rise);
    int t0, trise;
    bit got;
    start = 1'b1;
    step();
    start = 1'b0;
    t0 = cyc; trise = -1; got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      if (beep === 1'b1 && trise < 0) trise = cyc;
      if (done === 1'b1) got = 1;
    end
    check({name, "_done_lat"}, got ? 64'(cyc - t0) : '1, 64'(exp_lat));
    if (exp_rise >= 0) check({name, "_first_rise"}, 64'(trise - t0), 64'(exp_rise));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int i;
    for (i = 0; i < budget && busy; i++) step();
    check({name, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n_done;
    #3 rst = 1'b0;
    #1;
    check("rst_beep", beep, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_note_idx", note_idx, 3'd0);
    check("rst_cur_div", cur_div, 32'd0);
    check("rst_done", done, 1'b0);
    step(); step();
    rst = 1'b1;
    step();

    for (int a = 0; a < DEPTH; a++) write_entry(a, 0, 0);

    // Single note: LOAD + 16 PLAY + 2 GAP + end-marker LOAD = 20.
    write_entry(0, 2, 3);
    write_entry(1, 0, 0);
    loop_en = 1'b0;
    play_until_done("single", 60, 20, 4);
    step();

    // All rests, full wrap without end marker.
    for (int a = 0; a < DEPTH; a++) write_entry(a, 1, 0);
    play_until_done("rest_wrap", 120, 88, -1);
    step();

    // Loop: no done while looping, then done after loop_en drops.
    write_entry(0, 2, 3);
    write_entry(1, 0, 0);
    loop_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (done === 1'b1) n_done++;
    end
    check("loop_no_done", 64'(n_done), 64'd0);
    loop_en = 1'b0;
    n_done = 0;
    for (int i = 0; i < 60 && n_done == 0; i++) begin
      step();
      if (done === 1'b1) n_done++;
    end
    check("loop_exit_done", 64'(n_done), 64'd1);
    step();

    // Stop mid-PLAY with simultaneous start.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("stop_pre_busy", busy, 1'b1);
    stop = 1'b1; start = 1'b1;
    step();
    stop = 1'b0; start = 1'b0;
    check("stop_busy", busy, 1'b0);
    check("stop_beep", beep, 1'b0);
    check("stop_cur_div", cur_div, 32'd0);
    check("stop_done", done, 1'b0);
    step();
    play_until_done("after_stop", 60, 20, 4);
    step();

    // Live rewrite: current pass keeps period 3, next pass uses 5.
    loop_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    t0 = cyc;
    while (cyc < t0 + 6) step();
    write_entry(0, 2, 5);
    while (cyc < t0 + 25) step();
    check("rewrite_pre_rise", beep, 1'b0);
    step();
    check("rewrite_rise", beep, 1'b1);
    loop_en = 1'b0;
    wait_idle("rewrite", 80);
    step();

    // Async reset during GAP.
    write_entry(0, 2, 3);
    start = 1'b1; step(); start = 1'b0;
    t0 = cyc;
    while (cyc < t0 + 18) step();
    #1 rst = 1'b0;
    #1;
    check("arst_beep", beep, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_note_idx", note_idx, 3'd0);
    check("arst_cur_div", cur_div, 32'd0);
    check("arst_done", done, 1'b0);
    step(); step();
    rst = 1'b1;
    step();
    play_until_done("after_arst", 60, 20, 4);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      start   = ($urandom_range(0, 9) == 0);
      stop    = ($urandom_range(0, 60) == 0);
      loop_en = ($urandom_range(0, 3) != 0);
      wr_en   = ($urandom_range(0, 15) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_len  = 4'($urandom_range(0, 3));
      wr_div  = 32'($urandom_range(0, 4));
      step();
    end
    wr_en = 1'b0; start = 1'b0; loop_en = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;
    wait_idle("random", 10);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
